// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: datapath widths, fetch constants, fetch FSM encoding.
package wisc_pkg;

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 5;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [XLEN-1:0] DEF_NOP_INST = 16'h0800;
    localparam logic [OPW-1:0]  DEF_HALT_OP  = 5'b00000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2,
        HALTED  = 2'd3
    } fetch_state_e;

    // One fetched instruction together with its fall-through address.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc2;
    } fetch_entry_t;

    // Opcode field of a WISC instruction.
    function automatic logic [OPW-1:0] opcode(input logic [XLEN-1:0] inst);
        return inst[15:11];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetch result that arrived while decode was stalled.
module fetch_skid_buf
    import wisc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic         clr_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output logic         valid_o,
    output fetch_entry_t data_o
);

    logic         valid_q;
    fetch_entry_t data_q;

    // Capture on write; read-clear and flush both empty the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i || clr_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: PC, variable-latency imem handshake, skid buffer, IF/ID register.
module fetch_stage
    import wisc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST,
    parameter logic [OPW-1:0]  HALT_OP  = DEF_HALT_OP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch,
    input  logic [XLEN-1:0] pcbranch,
    output logic            imem_rd,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_done,
    output logic [XLEN-1:0] InstOut,
    output logic [XLEN-1:0] pcplus2Out,
    output logic            validOut,
    output logic            halted,
    output logic            err
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc2_q, pc2_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            err_q, err_d;

    logic            rd_c;
    logic [XLEN-1:0] addr_c;
    logic            wr_ifid;
    logic            bubble;
    fetch_entry_t    wr_entry;
    fetch_entry_t    res_entry;
    fetch_entry_t    buf_entry;
    logic            buf_v;
    logic            buf_wr;
    logic            buf_clr;
    logic            buf_flush;

    // Address is the live PC until a request is outstanding, then the captured request address.
    always_comb begin
        addr_c = pc_q;
        if (state_q == WAIT || state_q == DISCARD) begin
            addr_c = req_addr_q;
        end
    end

    assign imem_rd   = rd_c & ~rst;
    assign imem_addr = addr_c;
    assign res_entry = '{inst: imem_rdata, pc2: addr_c + XLEN'(2)};
    assign err_d     = err_q | (imem_rd & addr_c[0]);

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (buf_wr),
        .clr_i   (buf_clr),
        .flush_i (buf_flush),
        .data_i  (res_entry),
        .valid_o (buf_v),
        .data_o  (buf_entry)
    );

    // Request handshake, redirect/stall priority and IF/ID next-state selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        pc2_d      = pc2_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        rd_c       = 1'b0;
        wr_ifid    = 1'b0;
        bubble     = 1'b0;
        wr_entry   = res_entry;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        buf_flush  = 1'b0;

        case (state_q)
            FETCH: begin
                if (!stall && !buf_v && !branch) begin
                    rd_c       = 1'b1;
                    req_addr_d = pc_q;
                    if (imem_done) begin
                        wr_ifid = 1'b1;
                        pc_d    = pc_q + XLEN'(2);
                    end else begin
                        state_d = WAIT;
                        bubble  = 1'b1;
                    end
                end else if (branch) begin
                    pc_d      = pcbranch;
                    buf_flush = buf_v;
                    bubble    = 1'b1;
                end else if (buf_v && !stall) begin
                    wr_ifid  = 1'b1;
                    wr_entry = buf_entry;
                    buf_clr  = 1'b1;
                end
            end

            WAIT: begin
                rd_c = 1'b1;
                if (imem_done) begin
                    state_d = FETCH;
                    if (branch) begin
                        pc_d   = pcbranch;
                        bubble = 1'b1;
                    end else if (stall) begin
                        buf_wr = 1'b1;
                        pc_d   = pc_q + XLEN'(2);
                    end else begin
                        wr_ifid = 1'b1;
                        pc_d    = pc_q + XLEN'(2);
                    end
                end else if (branch) begin
                    pc_d    = pcbranch;
                    state_d = DISCARD;
                    bubble  = 1'b1;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end

            DISCARD: begin
                rd_c = 1'b1;
                if (imem_done) begin
                    state_d = FETCH;
                end
                if (branch) begin
                    pc_d   = pcbranch;
                    bubble = 1'b1;
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end

            HALTED: begin
                if (!stall) begin
                    bubble = 1'b1;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        if (wr_ifid) begin
            inst_d  = wr_entry.inst;
            pc2_d   = wr_entry.pc2;
            valid_d = 1'b1;
            if (opcode(wr_entry.inst) == HALT_OP) begin
                halted_d = 1'b1;
                state_d  = HALTED;
            end
        end else if (bubble) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_q     <= NOP_INST;
            pc2_q      <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            pc2_q      <= pc2_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
        end
    end

    assign InstOut    = inst_q;
    assign pcplus2Out = pc2_q;
    assign validOut   = valid_q;
    assign halted     = halted_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: latency-configurable memory model plus IF/ID scoreboard.
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc2;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [15:0] pcbranch;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic [15:0] InstOut;
    logic [15:0] pcplus2Out;
    logic        validOut;
    logic        halted;
    logic        err;

    int          n_checks;
    int          n_fail;
    int          lat;
    int          mcnt;
    logic [15:0] mem [0:255];
    exp_t        exp_q [$];
    logic [15:0] issue_log [$];
    logic        mon_stall;
    logic        mon_rst;
    exp_t        mon_e;

    localparam logic [15:0] NOP = 16'h0800;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branch     (branch),
        .pcbranch   (pcbranch),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_done  (imem_done),
        .InstOut    (InstOut),
        .pcplus2Out (pcplus2Out),
        .validOut   (validOut),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Memory: answers a request after 'lat' cycles of imem_rd (lat=1 -> same cycle).
    initial begin
        mcnt = 0;
        forever begin
            @(posedge clk);
            #6;
            if (rst || !imem_rd) begin
                mcnt       = 0;
                imem_done  = 1'b0;
                imem_rdata = 16'hDEAD;
            end else begin
                if (imem_done) mcnt = 0;
                mcnt = mcnt + 1;
                if (mcnt == 1) issue_log.push_back(imem_addr);
                imem_done  = (mcnt >= lat);
                imem_rdata = imem_done ? mem[imem_addr[8:1]] : 16'hDEAD;
            end
        end
    end

    // Scoreboard: every IF/ID write of a real instruction must match the next expected entry.
    initial begin
        forever begin
            @(posedge clk);
            mon_stall = stall;
            mon_rst   = rst;
            #1;
            if (!mon_rst && !rst && validOut && !mon_stall) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got inst=%h pc2=%h, required no IF/ID write", InstOut, pcplus2Out);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (InstOut !== mon_e.inst || pcplus2Out !== mon_e.pc2) begin
                        n_fail++;
                        $display("FAIL sb_ifid: got inst=%h pc2=%h, required inst=%h pc2=%h",
                                 InstOut, pcplus2Out, mon_e.inst, mon_e.pc2);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [15:0] inst, input logic [15:0] pc2);
        exp_t e;
        e.inst = inst;
        e.pc2  = pc2;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        stall    = 1'b0;
        branch   = 1'b0;
        pcbranch = 16'h0000;
        cyc();
        cyc();
        issue_log.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (InstOut !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h, required %h", InstOut, NOP); end
        n_checks++; if (pcplus2Out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc2: got %h, required 0000", pcplus2Out); end
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", validOut); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b, required 0", halted); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b, required 0", imem_rd); end
    endtask

    task automatic test_zero_latency();
        apply_reset();
        lat = 1;
        for (int i = 0; i < 4; i++) push_exp(16'h8000 | 16'(2 * i), 16'(2 * i + 2));
        rst = 1'b0;
        cyc();
        n_checks++; if (validOut !== 1'b1 || InstOut !== 16'h8000) begin n_fail++; $display("FAIL zl_first: got valid=%b inst=%h, required valid=1 inst=8000", validOut, InstOut); end
        cyc();
        cyc();
        cyc();
        stall = 1'b1;
        cyc();
        n_checks++; if (InstOut !== 16'h8006 || pcplus2Out !== 16'h0008 || validOut !== 1'b1) begin n_fail++; $display("FAIL zl_hold: got inst=%h pc2=%h valid=%b, required inst=8006 pc2=0008 valid=1", InstOut, pcplus2Out, validOut); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL zl_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_latency3();
        apply_reset();
        lat = 3;
        push_exp(16'h8000, 16'h0002);
        rst = 1'b0;
        #1;
        n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL l3_req0: got rd=%b addr=%h, required rd=1 addr=0000", imem_rd, imem_addr); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL l3_req: got rd=%b addr=%h, required rd=1 addr=0000", imem_rd, imem_addr); end
            n_checks++; if (validOut !== 1'b0 || InstOut !== NOP) begin n_fail++; $display("FAIL l3_bubble: got valid=%b inst=%h, required valid=0 inst=%h", validOut, InstOut, NOP); end
        end
        cyc();
        n_checks++; if (validOut !== 1'b1 || InstOut !== 16'h8000 || pcplus2Out !== 16'h0002) begin n_fail++; $display("FAIL l3_data: got valid=%b inst=%h pc2=%h, required 1/8000/0002", validOut, InstOut, pcplus2Out); end
        stall = 1'b1;
        cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL l3_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_branch_discard();
        logic got;
        apply_reset();
        lat = 4;
        push_exp(16'h8040, 16'h0042);
        rst = 1'b0;
        cyc();
        branch   = 1'b1;
        pcbranch = 16'h0040;
        cyc();
        branch = 1'b0;
        n_checks++; if (validOut !== 1'b0 || InstOut !== NOP) begin n_fail++; $display("FAIL bd_flush: got valid=%b inst=%h, required valid=0 inst=%h", validOut, InstOut, NOP); end
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            cyc();
            n_checks++; if (InstOut === 16'h8000) begin n_fail++; $display("FAIL bd_stale: got inst=%h, required never 8000", InstOut); end
            if (validOut) got = 1'b1;
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL bd_timeout: got no valid instruction, required 8040"); end
        n_checks++; if (InstOut !== 16'h8040 || pcplus2Out !== 16'h0042) begin n_fail++; $display("FAIL bd_target: got inst=%h pc2=%h, required 8040/0042", InstOut, pcplus2Out); end
        stall = 1'b1;
        n_checks++; if (issue_log.size() != 2 || issue_log[1] !== 16'h0040) begin n_fail++; $display("FAIL bd_issue: got %0d issues second=%h, required 2 issues second=0040", issue_log.size(), issue_log[1]); end
        cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bd_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_skid();
        apply_reset();
        lat = 2;
        push_exp(16'h8000, 16'h0002);
        push_exp(16'h8002, 16'h0004);
        rst = 1'b0;
        cyc();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL sk_rd_stall: got rd=%b, required 0", imem_rd); end
            n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL sk_hold: got valid=%b, required 0", validOut); end
        end
        stall = 1'b0;
        #1;
        n_checks++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL sk_rd_drain: got rd=%b, required 0", imem_rd); end
        cyc();
        n_checks++; if (validOut !== 1'b1 || InstOut !== 16'h8000 || pcplus2Out !== 16'h0002) begin n_fail++; $display("FAIL sk_out: got valid=%b inst=%h pc2=%h, required 1/8000/0002", validOut, InstOut, pcplus2Out); end
        n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0002) begin n_fail++; $display("FAIL sk_resume: got rd=%b addr=%h, required rd=1 addr=0002", imem_rd, imem_addr); end
        cyc();
        cyc();
        n_checks++; if (InstOut !== 16'h8002 || pcplus2Out !== 16'h0004) begin n_fail++; $display("FAIL sk_next: got inst=%h pc2=%h, required 8002/0004", InstOut, pcplus2Out); end
        stall = 1'b1;
        cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sk_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_halt();
        apply_reset();
        lat    = 1;
        mem[3] = 16'h0000;
        push_exp(16'h8000, 16'h0002);
        push_exp(16'h8002, 16'h0004);
        push_exp(16'h8004, 16'h0006);
        push_exp(16'h0000, 16'h0008);
        rst = 1'b0;
        cyc();
        cyc();
        cyc();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ht_early: got halted=%b, required 0", halted); end
        cyc();
        n_checks++; if (halted !== 1'b1 || InstOut !== 16'h0000 || validOut !== 1'b1) begin n_fail++; $display("FAIL ht_set: got halted=%b inst=%h valid=%b, required 1/0000/1", halted, InstOut, validOut); end
        branch   = 1'b1;
        pcbranch = 16'h0100;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_checks++; if (imem_rd !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL ht_frozen: got rd=%b halted=%b, required rd=0 halted=1", imem_rd, halted); end
        end
        branch = 1'b0;
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL ht_bubble: got valid=%b, required 0", validOut); end
        n_checks++; if (issue_log.size() != 4 || issue_log[3] !== 16'h0006) begin n_fail++; $display("FAIL ht_issue: got %0d issues last=%h, required 4 issues last=0006", issue_log.size(), issue_log[3]); end
        mem[3] = 16'h8006;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ht_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_branch_stall();
        apply_reset();
        lat = 1;
        push_exp(16'h8000, 16'h0002);
        push_exp(16'h8002, 16'h0004);
        push_exp(16'h8010, 16'h0013);
        rst = 1'b0;
        cyc();
        cyc();
        branch   = 1'b1;
        stall    = 1'b1;
        pcbranch = 16'h0011;
        cyc();
        n_checks++; if (validOut !== 1'b0 || InstOut !== NOP || err !== 1'b0) begin n_fail++; $display("FAIL bs_flush: got valid=%b inst=%h err=%b, required 0/%h/0", validOut, InstOut, err, NOP); end
        branch = 1'b0;
        stall  = 1'b0;
        #1;
        n_checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0011) begin n_fail++; $display("FAIL bs_pc: got rd=%b addr=%h, required rd=1 addr=0011", imem_rd, imem_addr); end
        cyc();
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bs_err: got err=%b, required 1", err); end
        stall = 1'b1;
        cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bs_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_wrap();
        apply_reset();
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err_rst: got err=%b, required 0", err); end
        lat = 1;
        push_exp(16'h81FE, 16'h0000);
        push_exp(16'h8000, 16'h0002);
        rst      = 1'b0;
        branch   = 1'b1;
        pcbranch = 16'hFFFE;
        cyc();
        n_checks++; if (validOut !== 1'b0) begin n_fail++; $display("FAIL wr_bubble: got valid=%b, required 0", validOut); end
        branch = 1'b0;
        cyc();
        n_checks++; if (InstOut !== 16'h81FE || pcplus2Out !== 16'h0000) begin n_fail++; $display("FAIL wr_top: got inst=%h pc2=%h, required 81FE/0000", InstOut, pcplus2Out); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_addr: got addr=%h, required 0000", imem_addr); end
        cyc();
        n_checks++; if (InstOut !== 16'h8000 || pcplus2Out !== 16'h0002) begin n_fail++; $display("FAIL wr_next: got inst=%h pc2=%h, required 8000/0002", InstOut, pcplus2Out); end
        stall = 1'b1;
        cyc();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wr_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        branch     = 1'b0;
        pcbranch   = 16'h0000;
        lat        = 1;
        imem_done  = 1'b0;
        imem_rdata = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i << 1);

        test_reset();
        test_zero_latency();
        test_latency3();
        test_branch_discard();
        test_skid();
        test_halt();
        test_branch_stall();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
